enemy_draw_scheduler: RTL and testbench

Sequences one row of up to NUM_SLOTS enemies through the single shared enemy sprite drawer, one enemy per draw. On each frame tick it advances the formation position with marching, edge-reversal and drop behaviour. It then issues one start/done handshake per alive enemy with that enemy's top-left coordinate. It sits between the game-level frame timer / alive mask and the sprite drawer, whose pixel outputs feed the VGA adapter.

---
 rtl/enemy_sched_pkg.sv | 48 ++++
 rtl/enemy_draw_scheduler_slot_find_first.sv | 37 +++
 rtl/enemy_draw_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_enemy_draw_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_sched_pkg.sv
// -----------------------------------------------------------------------------
// enemy_sched_pkg
//
// Shared types and constants for the enemy draw scheduler.
//   - state_t   : scheduler FSM states
//   - dir_t     : formation marching direction
//   - X_W / Y_W : screen coordinate widths
//   - SPAN_W    : width used for the formation right-edge test
//   - IDX_W     : slot index width; one bit wider than a 16-slot index needs,
//                 so the index can step one past the last slot
//   - drop_y()  : saturating vertical drop helper
// -----------------------------------------------------------------------------
package enemy_sched_pkg;

  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int SPAN_W    = 10;
  localparam int MAX_SLOTS = 16;
  localparam int IDX_W     = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOVE   = 3'd1,
    SCAN   = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  // y + drop, clamped to limit. One extra bit so the sum cannot wrap before
  // the comparison.
  function automatic logic [Y_W-1:0] drop_y(input logic [Y_W-1:0] y,
                                            input logic [Y_W:0]   drop,
                                            input logic [Y_W:0]   limit);
    logic [Y_W:0] sum;
    sum = {1'b0, y} + drop;
    if (sum > limit) begin
      return limit[Y_W-1:0];
    end
    return sum[Y_W-1:0];
  endfunction

endpackage

// File: rtl/enemy_draw_scheduler_slot_find_first.sv
// -----------------------------------------------------------------------------
// slot_find_first
//
// Combinational lowest-set-bit finder. Bits of mask below start_idx are
// ignored; the lowest remaining set bit is reported.
//
// Ports:
//   mask       in   NUM_SLOTS  candidate slots (bit i = slot i)
//   start_idx  in   IDX_W      first slot eligible; may equal NUM_SLOTS
//                              (then nothing is found)
//   found      out  1          a set bit exists at or above start_idx
//   found_idx  out  IDX_W      index of that bit (0 when found = 0)
// -----------------------------------------------------------------------------
module slot_find_first
  import enemy_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [IDX_W-1:0]     start_idx,
  output logic                 found,
  output logic [IDX_W-1:0]     found_idx
);

  // Walk from the top down so the last hit written is the lowest index.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= start_idx)) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_draw_scheduler.sv
// -----------------------------------------------------------------------------
// enemy_draw_scheduler
//
// Moves one row of enemies once per frame tick (march, edge reversal, drop)
// and then walks the alive slots, handing each enemy's top-left corner to the
// shared sprite drawer one at a time.
//
// Drawer handshake: draw_start is a single-cycle request. draw_x/draw_y are
// valid from the draw_start cycle and held stable until the drawer answers
// with a single-cycle draw_done. Exactly one draw_done is expected per
// draw_start; draw_done seen while not waiting on the drawer is ignored.
//
// Ports:
//   clk          in   1          system clock
//   reset        in   1          synchronous, active-high reset
//   frame_tick   in   1          request a move + redraw (ignored unless idle)
//   alive        in   NUM_SLOTS  slot alive mask, snapshotted on frame_tick
//   draw_done    in   1          drawer finished the current sprite
//   draw_start   out  1          single-cycle request to the drawer
//   draw_x       out  9          sprite origin x
//   draw_y       out  8          sprite origin y
//   formation_x  out  9          formation origin x
//   formation_y  out  8          formation origin y
//   busy         out  1          high in every state except IDLE
//   frame_done   out  1          single-cycle pulse after the last sprite
//   overrun      out  1          sticky: tick arrived while busy
//                                (only with ENEMY_SCHED_OVERRUN_EN defined)
//   dbg_state    out  state_t    current FSM state
//
// Build option: define ENEMY_SCHED_OVERRUN_EN to add the overrun flag.
// -----------------------------------------------------------------------------
module enemy_draw_scheduler
  import enemy_sched_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int COL_SPACING = 32,
  parameter int SPRITE_W    = 28,
  parameter int STEP        = 2,
  parameter int DROP        = 8,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 319,
  parameter int X_INIT      = 16,
  parameter int Y_INIT      = 16,
  parameter int Y_LIMIT     = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_SLOTS-1:0] alive,
  input  logic                 draw_done,
  output logic                 draw_start,
  output logic [X_W-1:0]       draw_x,
  output logic [Y_W-1:0]       draw_y,
  output logic [X_W-1:0]       formation_x,
  output logic [Y_W-1:0]       formation_y,
  output logic                 busy,
  output logic                 frame_done,
`ifdef ENEMY_SCHED_OVERRUN_EN
  output logic                 overrun,
`endif
  output state_t               dbg_state
);

  // Total formation width from the leftmost pixel of slot 0 to the
  // rightmost pixel of the last slot.
  localparam logic [SPAN_W-1:0] SPAN =
    SPAN_W'((NUM_SLOTS - 1) * COL_SPACING + SPRITE_W);
  localparam logic [SPAN_W-1:0] RIGHT_BOUND = SPAN_W'(X_MAX);
  localparam logic [X_W-1:0]    LEFT_BOUND  = X_W'(X_MIN + STEP);

  state_t                 state, state_n;
  dir_t                   dir, dir_n;
  logic [NUM_SLOTS-1:0]   mask, mask_n;
  logic [IDX_W-1:0]       slot_idx, idx_n;
  logic [X_W-1:0]         fx_n, dx_n;
  logic [Y_W-1:0]         fy_n, dy_n;
  logic [SPAN_W-1:0]      right_edge;
  logic                   found;
  logic [IDX_W-1:0]       found_idx;

  slot_find_first #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_find (
    .mask      (mask),
    .start_idx (slot_idx),
    .found     (found),
    .found_idx (found_idx)
  );

  // Rightmost pixel the formation would occupy after one more step right.
  assign right_edge = {1'b0, formation_x} + SPAN - SPAN_W'(1) + SPAN_W'(STEP);

  always_comb begin
    state_n = state;
    dir_n   = dir;
    mask_n  = mask;
    idx_n   = slot_idx;
    fx_n    = formation_x;
    fy_n    = formation_y;
    dx_n    = draw_x;
    dy_n    = draw_y;

    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_n = MOVE;
          mask_n  = alive;
          idx_n   = '0;
        end
      end

      MOVE: begin
        state_n = SCAN;
        // A reversal frame only drops; x stays put until the next frame.
        if (dir == DIR_RIGHT) begin
          if (right_edge > RIGHT_BOUND) begin
            dir_n = DIR_LEFT;
            fy_n  = drop_y(formation_y, (Y_W+1)'(DROP), (Y_W+1)'(Y_LIMIT));
          end else begin
            fx_n = formation_x + X_W'(STEP);
          end
        end else begin
          if (formation_x < LEFT_BOUND) begin
            dir_n = DIR_RIGHT;
            fy_n  = drop_y(formation_y, (Y_W+1)'(DROP), (Y_W+1)'(Y_LIMIT));
          end else begin
            fx_n = formation_x - X_W'(STEP);
          end
        end
      end

      SCAN: begin
        if (found) begin
          state_n = START;
          idx_n   = found_idx;
          dx_n    = formation_x + X_W'(int'(found_idx) * COL_SPACING);
          dy_n    = formation_y;
        end else begin
          state_n = FINISH;
        end
      end

      START: begin
        state_n = WAIT;
      end

      WAIT: begin
        // Stepping past the last slot is fine: the next SCAN finds nothing
        // and goes to FINISH, which keeps done-to-frame_done at two cycles.
        if (draw_done) begin
          state_n = SCAN;
          idx_n   = slot_idx + IDX_W'(1);
        end
      end

      FINISH: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dir         <= DIR_RIGHT;
      mask        <= '0;
      slot_idx    <= '0;
      formation_x <= X_W'(X_INIT);
      formation_y <= Y_W'(Y_INIT);
      draw_x      <= '0;
      draw_y      <= '0;
      draw_start  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      dir         <= dir_n;
      mask        <= mask_n;
      slot_idx    <= idx_n;
      formation_x <= fx_n;
      formation_y <= fy_n;
      draw_x      <= dx_n;
      draw_y      <= dy_n;
      // Registered strobes: high exactly while in START / FINISH.
      draw_start  <= (state_n == START);
      frame_done  <= (state_n == FINISH);
    end
  end

`ifdef ENEMY_SCHED_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (frame_tick && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end
`endif

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_enemy_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_enemy_draw_scheduler
//
// Randomized bench for enemy_draw_scheduler. A behavioural model tracks the
// formation position with plain integer arithmetic and builds the expected
// list of sprite origins per frame; a drawer stand-in answers each
// draw_start after a random delay. Timing of first start, per-sprite
// overhead and frame_done latency is checked against fixed cycle counts.
// -----------------------------------------------------------------------------
module tb_enemy_draw_scheduler;
  import enemy_sched_pkg::*;

  localparam int NS   = 8;
  localparam int SP   = 32;
  localparam int SW   = 28;
  localparam int STP  = 2;
  localparam int DRP  = 8;
  localparam int XMIN = 0;
  localparam int XMAX = 319;
  localparam int XI   = 16;
  localparam int YI   = 16;
  localparam int YLIM = 200;
  localparam int EW   = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          frame_tick;
  logic [NS-1:0] alive;
  logic          draw_done;
  logic          draw_start;
  logic [8:0]    draw_x;
  logic [7:0]    draw_y;
  logic [8:0]    formation_x;
  logic [7:0]    formation_y;
  logic          busy;
  logic          frame_done;
`ifdef ENEMY_SCHED_OVERRUN_EN
  logic          overrun;
`endif
  state_t        dbg_state;

  enemy_draw_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .alive       (alive),
    .draw_done   (draw_done),
    .draw_start  (draw_start),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .formation_x (formation_x),
    .formation_y (formation_y),
    .busy        (busy),
    .frame_done  (frame_done),
`ifdef ENEMY_SCHED_OVERRUN_EN
    .overrun     (overrun),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_frame_done = 0;
  logic [EW-1:0] exp_q[$];

  // Counted on the active edge so the value seen is the one held in the
  // cycle that just ended.
  always @(posedge clk) begin
    if (frame_done === 1'b1) n_frame_done <= n_frame_done + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x, m_y;
  bit m_right;

  task automatic model_reset();
    m_x = XI;
    m_y = YI;
    m_right = 1'b1;
  endtask

  task automatic model_move();
    int span;
    span = (NS - 1) * SP + SW;
    if (m_right) begin
      if (m_x + span - 1 + STP > XMAX) begin
        m_right = 1'b0;
        m_y = (m_y + DRP > YLIM) ? YLIM : m_y + DRP;
      end else begin
        m_x = m_x + STP;
      end
    end else begin
      if (m_x < XMIN + STP) begin
        m_right = 1'b1;
        m_y = (m_y + DRP > YLIM) ? YLIM : m_y + DRP;
      end else begin
        m_x = m_x - STP;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      alive     = NS'($urandom);
      draw_done = 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    draw_done = 1'b0;
  endtask

  // One complete frame. Called at a negedge with the DUT idle. With
  // reset_after >= 0 the frame is abandoned by asserting reset in the wait
  // cycle following start number reset_after (0-based); reset is left high.
  task automatic run_frame(input logic [NS-1:0] a, input int dmin,
                           input int dmax, input bit inject,
                           input int reset_after);
    int last_ref, wait_cnt, n_start, fd_before;
    bit first, got_fd, injected, stop;
    logic [8:0] hx;
    logic [7:0] hy;
    logic [EW-1:0] e;

    model_move();
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      if (a[i]) exp_q.push_back({9'(m_x + i * SP), 8'(m_y)});
    end
    fd_before = n_frame_done;
    alive = a;
    frame_tick = 1'b1;
    last_ref = 0; wait_cnt = 0; n_start = 0;
    first = 1'b1; got_fd = 1'b0; injected = 1'b0; stop = 1'b0;
    hx = '0; hy = '0;

    for (int c = 1; c <= 4000 && !got_fd && !stop; c++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      draw_done  = 1'b0;
      alive      = NS'($urandom);
      if (draw_start === 1'b1) begin
        check_eq("start_latency", c - last_ref, first ? 3 : 2);
        first = 1'b0;
        n_start++;
        if (exp_q.size() == 0) begin
          check_eq("extra_start", n_start, $countones(a));
        end else begin
          e = exp_q.pop_front();
          check_eq("draw_x", draw_x, e[16:8]);
          check_eq("draw_y", draw_y, e[7:0]);
        end
        hx = draw_x;
        hy = draw_y;
        wait_cnt = $urandom_range(dmax, dmin);
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (inject && !injected) begin
          frame_tick = 1'b1;
          injected = 1'b1;
        end
        if (reset_after >= 0 && n_start == reset_after + 1) begin
          reset = 1'b1;
          stop = 1'b1;
        end else if (wait_cnt == 0) begin
          draw_done = 1'b1;
          last_ref = c;
          check_eq("hold_x", draw_x, hx);
          check_eq("hold_y", draw_y, hy);
          check_eq("busy_wait", busy, 1);
        end
      end
      if (frame_done === 1'b1) begin
        got_fd = 1'b1;
        check_eq("frame_done_latency", c - last_ref, first ? 3 : 2);
      end
    end

    if (!stop) begin
      if (!got_fd) check_eq("frame_done_timeout", 0, 1);
      check_eq("start_count", n_start, $countones(a));
      check_eq("exp_left", exp_q.size(), 0);
      check_eq("formation_x", formation_x, m_x);
      check_eq("formation_y", formation_y, m_y);
      check_eq("y_limit", (formation_y <= YLIM), 1);
      @(negedge clk);
      draw_done = 1'b0;
      check_eq("idle_busy", busy, 0);
      check_eq("idle_state", dbg_state, IDLE);
      check_eq("frame_count", n_frame_done - fd_before, 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"},  dbg_state, IDLE);
    check_eq({tag, "_busy"},   busy, 0);
    check_eq({tag, "_fx"},     formation_x, XI);
    check_eq({tag, "_fy"},     formation_y, YI);
    check_eq({tag, "_dx"},     draw_x, 0);
    check_eq({tag, "_dy"},     draw_y, 0);
    check_eq({tag, "_start"},  draw_start, 0);
    check_eq({tag, "_fdone"},  frame_done, 0);
`ifdef ENEMY_SCHED_OVERRUN_EN
    check_eq({tag, "_overrun"}, overrun, 0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NS-1:0] a;
    reset = 1'b1;
    frame_tick = 1'b0;
    draw_done = 1'b0;
    alive = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    model_reset();

    // Full row, fixed 5-cycle drawer.
    run_frame(8'hFF, 5, 5, 1'b0, -1);
    // Only the two end slots.
    run_frame(8'h81, 1, 6, 1'b0, -1);
    // Empty frame still moves.
    run_frame(8'h00, 1, 1, 1'b0, -1);
`ifdef ENEMY_SCHED_OVERRUN_EN
    check_eq("overrun_clear", overrun, 0);
`endif
    // Tick during WAIT is dropped.
    a = NS'($urandom) | NS'(1);
    run_frame(a, 2, 4, 1'b1, -1);
`ifdef ENEMY_SCHED_OVERRUN_EN
    check_eq("overrun_set", overrun, 1);
`endif
    idle_cycles(3);
`ifdef ENEMY_SCHED_OVERRUN_EN
    check_eq("overrun_sticky", overrun, 1);
`endif

    // Reset while waiting on slot 3.
    run_frame(8'hFF, 2, 4, 1'b0, 3);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("mid_reset");
    model_reset();
    run_frame(8'hFF, 1, 3, 1'b0, -1);

    // Long run: many edge reversals and y saturation.
    for (int f = 0; f < 1000; f++) begin
      a = ($urandom_range(7, 0) == 0) ? NS'($urandom) : '0;
      run_frame(a, 1, 3, 1'b0, -1);
      if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(2, 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
